alu_seq8: RTL
=============

// Module: alu_seq8
// PURPOSE
//  Sequencer/arbiter that time-shares the 4-bit combinational ALU between two requesters.
//  Executes 8-bit ADD/SUB/AND/OR as 2-3 nibble passes: low pass, high pass, optional carry-fix pass.
//  Drives the ALU inputs (A, B, L, ALUop) from registers and samples its R/carry outputs.
//  Sits between the ALU instance and the two client units (req/gnt/done handshake).
// PARAMETERS
//  ENC_ADD  3'b000  {L,ALUop} driven to ALU for nibble add (A+B, carry out = unsigned carry)
//  ENC_SUB  3'b001  {L,ALUop} for nibble subtract (A-B, carry out = 1 when no borrow)
//  ENC_AND  3'b100  {L,ALUop} for bitwise AND
//  ENC_OR   3'b101  {L,ALUop} for bitwise OR
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous reset, active high
//  req0/req1  in   1  request from client 0/1, level; held until gnt
//  op0/op1    in   2  operation: 00 ADD, 01 SUB, 10 AND, 11 OR
//  a0,b0/a1,b1 in  8  operands of client 0/1, sampled on grant
//  gnt0/gnt1  out  1  one-cycle pulse: request accepted, operands captured
//  done0/done1 out 1  one-cycle pulse: res/flags valid for that client
//  res        out  8  result, held until next done
//  res_zero   out  1  res == 8'h00
//  res_carry  out  1  ADD: carry out; SUB: 1 = no borrow; AND/OR: 0
//  res_sign   out  1  res[7]
//  busy       out  1  high in every state except IDLE
//  alu_a,alu_b out 4  ALU operands
//  alu_l      out  1  ALU logic/arith select
//  alu_op     out  2  ALU operation select
//  alu_r      in   4  ALU result (combinational from alu_* outputs)
//  alu_carry  in   1  ALU carry out
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (res, flags, gnt*, done*, busy, alu_*); owner = client 0.
//  States: IDLE -> LO -> HI -> [FIX] -> DONE -> IDLE. One ALU pass per cycle in LO/HI/FIX.
//  IDLE: if any req: assert gnt of winner, latch op/a/b/owner, go LO. Fixed priority: req0 wins.
//  LO: drive low nibbles with op encoding; at edge latch res[3:0], c_lo = alu_carry.
//  HI: drive high nibbles; latch r_hi, c_hi.
//   ADD: go FIX if c_lo=1, else DONE. SUB: go FIX if c_lo=0 (borrow), else DONE. AND/OR: DONE.
//  FIX: alu_a=r_hi, alu_l/op=ENC_ADD; alu_b=4'h1 (ADD) or 4'hF (SUB, i.e. -1); latch r_hi, c_fix.
//  Carry: ADD = c_hi | c_fix; SUB = c_hi & c_fix; no FIX pass -> c_hi; AND/OR -> 0.
//  DONE: res/flags registered; done of owner pulses this cycle; next state IDLE.
//  Latency gnt->done: 3 cycles (no FIX), 4 cycles (FIX). New grant earliest cycle after DONE.
//  Requests arriving while busy are ignored until IDLE; req still high after own done -> new op.
//  res/flags change only in DONE; alu_* outputs 0 in IDLE and DONE.
//  Both req in same IDLE cycle: only one gnt; loser stays pending, served next IDLE.
//  Reset mid-operation: immediate abort, no done pulse, operation lost, client must re-request.
// CONFIGURATION
//  ALU_SEQ8_RR_EN defined: round-robin arbitration; on simultaneous req the client not served
//   last wins (last-served pointer updated on gnt, reset value = client 1 so client 0 wins first).
//  Not defined: fixed priority, req0 always wins; client 1 can starve.
// TESTING
//  ADD a0=8'h3A b0=8'h27 -> res 8'h61, carry 0, zero 0, sign 0; FIX pass used, done0 4 cycles after gnt0.
//  ADD a0=8'hFF b0=8'h01 -> res 8'h00, carry 1, zero 1, sign 0.
//  SUB a1=8'h00 b1=8'h01 -> res 8'hFF, carry 0 (borrow), sign 1; SUB 8'h10-8'h01 -> 8'h0F, carry 1.
//  AND 8'hF0&8'h3C -> 8'h30, carry 0, done 3 cycles after gnt; OR 8'h0F|8'hA0 -> 8'hAF.
//  req0 and req1 high together, held: fixed -> gnt0 repeatedly, no gnt1;
//   with ALU_SEQ8_RR_EN -> gnt0, gnt1, gnt0 alternating.
//  Assert reset during HI state -> all outputs 0 immediately, no done pulse; next req served normally.

Source files
------------

// File: rtl/alu_seq8.sv
// Time-shares a 4-bit ALU between two clients to run 8-bit ADD/SUB/AND/OR in 2-3 nibble passes.
// Latency gnt->done is 3 cycles, or 4 with a carry-fix pass. Requests wait while busy; there is no other backpressure.
// Define ALU_SEQ8_RR_EN for round-robin arbitration. The default is fixed priority, with client 0 winning.
module alu_seq8 (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [1:0] op0,
   input  logic [1:0] op1,
   input  logic [7:0] a0,
   input  logic [7:0] b0,
   input  logic [7:0] a1,
   input  logic [7:0] b1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [7:0] res,
   output logic       res_zero,
   output logic       res_carry,
   output logic       res_sign,
   output logic       busy,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic       alu_l,
   output logic [1:0] alu_op,
   input  logic [3:0] alu_r,
   input  logic       alu_carry
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LO   = 3'd1;
   localparam logic [2:0] S_HI   = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [2:0] ENC_ADD = 3'b000;
   localparam logic [2:0] ENC_SUB = 3'b001;
   localparam logic [2:0] ENC_AND = 3'b100;
   localparam logic [2:0] ENC_OR  = 3'b101;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;

   logic [2:0] state;
   logic [1:0] op_q;
   logic [3:0] a_hi;
   logic [3:0] b_hi;
   logic [3:0] r_lo;
   logic       c_lo;
   logic       c_hi;
   logic       owner;
   logic       pick1;
   logic       need_fix;
   logic [1:0] sel_op;
   logic [7:0] sel_a;
   logic [7:0] sel_b;
   logic [7:0] res_hi_pass;
   logic [7:0] res_fix_pass;

   function automatic logic [2:0] enc_of(input logic [1:0] op);
      case (op)
         2'b00:   enc_of = ENC_ADD;
         2'b01:   enc_of = ENC_SUB;
         2'b10:   enc_of = ENC_AND;
         default: enc_of = ENC_OR;
      endcase
   endfunction

`ifdef ALU_SEQ8_RR_EN
   logic last_served;

   // On a tie the client not served last wins; the reset value of 1 lets client 0 win first.
   assign pick1 = req1 & (~req0 | ~last_served);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_served <= 1'b1;
      else if (state == S_IDLE && (req0 || req1))
         last_served <= pick1;
   end
`else
   assign pick1 = req1 & ~req0;
`endif

   assign sel_op = pick1 ? op1 : op0;
   assign sel_a  = pick1 ? a1 : a0;
   assign sel_b  = pick1 ? b1 : b0;

   assign gnt0  = (state == S_IDLE) & ~reset & req0 & ~pick1;
   assign gnt1  = (state == S_IDLE) & ~reset & pick1;
   assign done0 = (state == S_DONE) & ~owner;
   assign done1 = (state == S_DONE) & owner;
   assign busy  = (state != S_IDLE);

   // The high pass runs without carry-in, so a low-nibble carry (ADD) or borrow (SUB) is applied in FIX.
   assign need_fix     = ((op_q == OP_ADD) & c_lo) | ((op_q == OP_SUB) & ~c_lo);
   assign res_hi_pass  = {alu_r, r_lo};
   assign res_fix_pass = {alu_r, r_lo};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         op_q      <= 2'b00;
         a_hi      <= 4'h0;
         b_hi      <= 4'h0;
         r_lo      <= 4'h0;
         c_lo      <= 1'b0;
         c_hi      <= 1'b0;
         owner     <= 1'b0;
         res       <= 8'h00;
         res_zero  <= 1'b0;
         res_carry <= 1'b0;
         res_sign  <= 1'b0;
         alu_a     <= 4'h0;
         alu_b     <= 4'h0;
         alu_l     <= 1'b0;
         alu_op    <= 2'b00;
      end else begin
         case (state)
            S_IDLE: begin
               if (req0 || req1) begin
                  owner                <= pick1;
                  op_q                 <= sel_op;
                  a_hi                 <= sel_a[7:4];
                  b_hi                 <= sel_b[7:4];
                  alu_a                <= sel_a[3:0];
                  alu_b                <= sel_b[3:0];
                  {alu_l, alu_op}      <= enc_of(sel_op);
                  state                <= S_LO;
               end
            end
            S_LO: begin
               r_lo  <= alu_r;
               c_lo  <= alu_carry;
               alu_a <= a_hi;
               alu_b <= b_hi;
               state <= S_HI;
            end
            S_HI: begin
               c_hi <= alu_carry;
               if (need_fix) begin
                  alu_a           <= alu_r;
                  alu_b           <= (op_q == OP_ADD) ? 4'h1 : 4'hF;
                  {alu_l, alu_op} <= ENC_ADD;
                  state           <= S_FIX;
               end else begin
                  res             <= res_hi_pass;
                  res_zero        <= (res_hi_pass == 8'h00);
                  res_sign        <= res_hi_pass[7];
                  res_carry       <= op_q[1] ? 1'b0 : alu_carry;
                  alu_a           <= 4'h0;
                  alu_b           <= 4'h0;
                  {alu_l, alu_op} <= 3'b000;
                  state           <= S_DONE;
               end
            end
            S_FIX: begin
               res             <= res_fix_pass;
               res_zero        <= (res_fix_pass == 8'h00);
               res_sign        <= res_fix_pass[7];
               res_carry       <= (op_q == OP_ADD) ? (c_hi | alu_carry) : (c_hi & alu_carry);
               alu_a           <= 4'h0;
               alu_b           <= 4'h0;
               {alu_l, alu_op} <= 3'b000;
               state           <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
